// File: rtl/flash_ctrl_pkg.sv
// Shared types and constants for the flash controller program path.
package flash_ctrl_pkg;

  localparam int unsigned ProgWordW = 64;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StProg   = 2'd1,
    StFinish = 2'd2
  } prog_state_e;

endpackage

// File: rtl/flash_prog_seq.sv
// Program-operation sequencer: walks a word range, pulls each word from the
// program FIFO, issues one request per word and reports done/error.
module flash_prog_seq
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned AddrW = 16,
  parameter int unsigned WordW = ProgWordW,
  parameter int unsigned CntW  = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             op_start_i,
  input  logic [CntW-1:0]  op_num_words_i,
  input  logic [AddrW-1:0] op_addr_i,
  input  logic             data_rvalid_i,
  input  logic [WordW-1:0] data_i,
  output logic             data_rready_o,
  output logic             req_o,
  output logic [AddrW-1:0] addr_o,
  output logic             addr_ovfl_o,
  output logic [WordW-1:0] prog_data_o,
  output logic             last_o,
  input  logic             done_i,
  input  logic             error_i,
  output logic             busy_o,
  output logic             op_done_o,
  output logic             op_err_o,
  output logic [AddrW-1:0] err_addr_o
);

  prog_state_e      r_state;
  logic [AddrW-1:0] r_base;
  logic [CntW-1:0]  r_limit;
  logic [CntW-1:0]  r_cnt;
  logic             r_err_q;
  logic [AddrW-1:0] r_err_addr;

  logic             w_in_prog;
  logic [AddrW:0]   w_sum;
  logic             w_last;

  // One extra bit so a wrap past the top of the address space is visible.
  assign w_sum     = {1'b0, r_base} + {{(AddrW + 1 - CntW){1'b0}}, r_cnt};
  assign w_in_prog = (r_state == StProg);
  assign w_last    = (r_cnt == r_limit);

  assign req_o         = w_in_prog & data_rvalid_i;
  assign addr_o        = w_sum[AddrW-1:0];
  assign addr_ovfl_o   = w_sum[AddrW];
  assign prog_data_o   = w_in_prog ? data_i : {WordW{1'b0}};
  assign last_o        = w_in_prog & w_last;
  assign data_rready_o = w_in_prog & done_i;
  assign busy_o        = (r_state != StIdle);
  assign op_done_o     = (r_state == StFinish);
  assign op_err_o      = (r_state == StFinish) & r_err_q;
  assign err_addr_o    = r_err_addr;

  // Sequencer FSM with word counter; a failing word ends the operation at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_base     <= {AddrW{1'b0}};
      r_limit    <= {CntW{1'b0}};
      r_cnt      <= {CntW{1'b0}};
      r_err_q    <= 1'b0;
      r_err_addr <= {AddrW{1'b0}};
    end else begin
      case (r_state)
        StIdle: begin
          if (op_start_i) begin
            r_base  <= op_addr_i;
            r_limit <= op_num_words_i;
            r_cnt   <= {CntW{1'b0}};
            r_err_q <= 1'b0;
            r_state <= StProg;
          end
        end
        StProg: begin
          if (done_i) begin
            if (error_i) begin
              r_err_q    <= 1'b1;
              r_err_addr <= w_sum[AddrW-1:0];
              r_state    <= StFinish;
            end else if (w_last) begin
              r_err_q <= 1'b0;
              r_state <= StFinish;
            end else begin
              r_cnt <= r_cnt + {{(CntW - 1){1'b0}}, 1'b1};
            end
          end
        end
        StFinish: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
